// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array host-side scheduler.
package systolic_pkg;

  // Scheduler phases, in the order a job walks through them.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    SHIFT_W = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } sched_state_t;

  // Default geometry, used by the row-vector typedef below.
  localparam int DEF_MATRIX_SIZE = 2;
  localparam int DEF_DATA_SIZE   = 32;

  // One row of N lanes; lane k lives in bits [k*DATA_SIZE +: DATA_SIZE].
  typedef logic [DEF_MATRIX_SIZE-1:0][DEF_DATA_SIZE-1:0] row_vec_t;

  // Cycles from an accepted activation row to its aligned result row:
  // array latency to column 0, N-1 cycles of deskew, one output register.
  function automatic int result_latency(input int array_lat, input int n);
    return array_lat + n;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register used for input skew, fire-bit skew and
// output deskew. DEPTH=0 collapses to a plain wire.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign dout = din;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
    logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

    // Next state: new sample enters stage 0, every stage moves one down.
    always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = din;
      for (int k = 1; k < DEPTH; k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end

    // Stage registers, cleared by reset so no stale data survives an abort.
    always_ff @(posedge clk) begin
      if (reset) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign dout = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_scheduler.sv
// Host-side initiator for a weight-stationary systolic array: buffers one
// NxN weight tile, shifts it into the array with column skew, streams
// activation rows with row skew and deskews the bottom-row sums.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. w_ready/a_ready depend only on internal state, never on the
// matching valid. r_valid has no backpressure; the consumer must take it.
module systolic_scheduler
  import systolic_pkg::*;
#(
  parameter  int MATRIX_SIZE = 2,
  parameter  int DATA_SIZE   = 32,
  parameter  int MAX_ROWS    = 16,
  parameter  int ARRAY_LAT   = 2,
  localparam int RW          = $clog2(MAX_ROWS + 1),
  localparam int IW          = $clog2(MAX_ROWS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [RW-1:0]                          num_rows,
  output logic                                   busy,
  output logic                                   done,
  input  logic                                   w_valid,
  output logic                                   w_ready,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  w_data,
  input  logic                                   a_valid,
  output logic                                   a_ready,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  a_data,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  in_data,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  in_weights,
  output logic [MATRIX_SIZE-1:0]                 load_weight,
  output logic [MATRIX_SIZE-1:0]                 enable_mult,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  out_sum,
  output logic                                   r_valid,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  r_data,
  output logic [IW-1:0]                          r_index,
  output logic [2:0]                             dbg_state
);

  localparam int N         = MATRIX_SIZE;
  localparam int KW        = $clog2(N + 1);
  localparam int CW        = $clog2(2 * N);
  // Fire token is taken one cycle early so it lines up with the deskewed
  // sums entering the output register.
  localparam int TOK_DEPTH = result_latency(ARRAY_LAT, N) - 1;

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_LOAD_W  = LOAD_W;
  localparam logic [2:0] ST_SHIFT_W = SHIFT_W;
  localparam logic [2:0] ST_COMPUTE = COMPUTE;
  localparam logic [2:0] ST_DRAIN   = DRAIN;

  logic [2:0]                              state_q, state_d;
  logic [RW-1:0]                           nrows_q, nrows_d;
  logic [RW-1:0]                           acc_q, acc_d;
  logic [RW-1:0]                           emit_q, emit_d;
  logic [KW-1:0]                           wcnt_q, wcnt_d;
  logic [CW-1:0]                           shcnt_q, shcnt_d;
  logic [N-1:0][N-1:0][DATA_SIZE-1:0]      tile_q, tile_d;
  logic                                    r_valid_q, r_valid_d;
  logic [N-1:0][DATA_SIZE-1:0]             r_data_q, r_data_d;
  logic                                    fire;
  logic                                    tok_pre;
  logic [N-1:0][DATA_SIZE-1:0]             desk;

  // Job sequencing: phase transitions, counters, tile capture, handshakes.
  always_comb begin
    state_d = state_q;
    nrows_d = nrows_q;
    acc_d   = acc_q;
    emit_d  = emit_q + RW'(r_valid_q);
    wcnt_d  = wcnt_q;
    shcnt_d = shcnt_q;
    tile_d  = tile_q;
    w_ready = 1'b0;
    a_ready = 1'b0;
    fire    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nrows_d = (int'(num_rows) > MAX_ROWS) ? RW'(MAX_ROWS) : num_rows;
          acc_d   = '0;
          emit_d  = '0;
          wcnt_d  = '0;
          state_d = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          for (int k = 0; k < N; k++) begin
            if (int'(wcnt_q) == k) tile_d[k] = w_data;
          end
          wcnt_d = wcnt_q + KW'(1);
          if (int'(wcnt_q) == N - 1) begin
            shcnt_d = '0;
            state_d = ST_SHIFT_W;
          end
        end
      end
      ST_SHIFT_W: begin
        shcnt_d = shcnt_q + CW'(1);
        if (int'(shcnt_q) == 2 * N - 2) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        a_ready = (acc_q < nrows_q);
        fire    = a_valid && a_ready;
        acc_d   = acc_q + RW'(fire);
        if (acc_d == nrows_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // emit_q counts rows already presented on r_valid, so done lands
        // the cycle after the last result (or at once for an empty job).
        if (emit_q == nrows_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Weight shift-in: bottom row first, column j delayed j cycles.
  always_comb begin
    in_weights  = '0;
    load_weight = '0;
    if (state_q == ST_SHIFT_W) begin
      if (int'(shcnt_q) <= N - 1) load_weight = '1;
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(shcnt_q) - j == N - 1 - k) in_weights[j] = tile_q[k][j];
        end
      end
    end
  end

  // Row skew: lane i and its fire bit are delayed i cycles together;
  // bubbles carry zero data with enable low.
  for (genvar i = 0; i < N; i++) begin : g_in_skew
    logic [DATA_SIZE:0] lane_in;
    logic [DATA_SIZE:0] lane_out;
    assign lane_in = {fire, a_data[i] & {DATA_SIZE{fire}}};
    skew_delay_line #(.DEPTH(i), .WIDTH(DATA_SIZE + 1)) u_skew (
      .clk  (clk),
      .reset(reset),
      .din  (lane_in),
      .dout (lane_out)
    );
    assign enable_mult[i] = lane_out[DATA_SIZE];
    assign in_data[i]     = lane_out[DATA_SIZE-1:0];
  end

  // Column deskew: column j arrives j cycles late, so it waits N-1-j.
  for (genvar j = 0; j < N; j++) begin : g_out_deskew
    skew_delay_line #(.DEPTH(N - 1 - j), .WIDTH(DATA_SIZE)) u_desk (
      .clk  (clk),
      .reset(reset),
      .din  (out_sum[j]),
      .dout (desk[j])
    );
  end

  skew_delay_line #(.DEPTH(TOK_DEPTH), .WIDTH(1)) u_tok (
    .clk  (clk),
    .reset(reset),
    .din  (fire),
    .dout (tok_pre)
  );

  // Output register input: only aligned rows are captured, otherwise zero.
  always_comb begin
    r_valid_d = tok_pre;
    r_data_d  = tok_pre ? desk : '0;
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      nrows_q   <= '0;
      acc_q     <= '0;
      emit_q    <= '0;
      wcnt_q    <= '0;
      shcnt_q   <= '0;
      tile_q    <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      nrows_q   <= nrows_d;
      acc_q     <= acc_d;
      emit_q    <= emit_d;
      wcnt_q    <= wcnt_d;
      shcnt_q   <= shcnt_d;
      tile_q    <= tile_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign r_valid   = r_valid_q;
  assign r_data    = r_data_q;
  assign r_index   = emit_q[IW-1:0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_scheduler.sv
// Bench for systolic_scheduler driving a behavioural 2x2 weight-stationary
// array; results are scored against a golden matrix product.
module tb_systolic_scheduler;

  localparam int N        = 2;
  localparam int D        = 32;
  localparam int MAX_ROWS = 16;
  localparam int LAT      = 2;
  localparam int RW       = 5;
  localparam int IW       = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                   start;
  logic [RW-1:0]          num_rows;
  logic                   busy, done;
  logic                   w_valid, w_ready;
  logic [N-1:0][D-1:0]    w_data;
  logic                   a_valid, a_ready;
  logic [N-1:0][D-1:0]    a_data;
  logic [N-1:0][D-1:0]    in_data, in_weights, out_sum, r_data;
  logic [N-1:0]           load_weight, enable_mult;
  logic                   r_valid;
  logic [IW-1:0]          r_index;
  logic [2:0]             dbg_state;

  systolic_scheduler #(.MATRIX_SIZE(N), .DATA_SIZE(D), .MAX_ROWS(MAX_ROWS), .ARRAY_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .in_data(in_data), .in_weights(in_weights), .load_weight(load_weight),
    .enable_mult(enable_mult), .out_sum(out_sum),
    .r_valid(r_valid), .r_data(r_data), .r_index(r_index), .dbg_state(dbg_state)
  );

  // ---------------- behavioural array ----------------
  // Weights shift down a column while the row's load flag (delayed j
  // cycles along the row) is high; activations move right, sums move down.
  logic [D-1:0] pe_w_q  [N][N];
  logic [D-1:0] pe_a_q  [N][N];
  logic [D-1:0] pe_ps_q [N][N];
  logic         pe_en_q [N][N];
  logic         pe_ld_q [N][N];
  logic [D-1:0] cur_a   [N][N];
  logic         cur_en  [N][N];
  logic         cur_ld  [N][N];
  logic [D-1:0] w_above [N][N];
  logic [D-1:0] ps_above[N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_left
        assign cur_a[i][j]  = in_data[i];
        assign cur_en[i][j] = enable_mult[i];
        assign cur_ld[i][j] = load_weight[i];
      end else begin : g_inner
        assign cur_a[i][j]  = pe_a_q[i][j-1];
        assign cur_en[i][j] = pe_en_q[i][j-1];
        assign cur_ld[i][j] = pe_ld_q[i][j-1];
      end
      if (i == 0) begin : g_top
        assign w_above[i][j]  = in_weights[j];
        assign ps_above[i][j] = '0;
      end else begin : g_below
        assign w_above[i][j]  = pe_w_q[i-1][j];
        assign ps_above[i][j] = pe_ps_q[i-1][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (reset) begin
          pe_w_q[i][j]  <= '0;
          pe_a_q[i][j]  <= '0;
          pe_ps_q[i][j] <= '0;
          pe_en_q[i][j] <= 1'b0;
          pe_ld_q[i][j] <= 1'b0;
        end else begin
          pe_a_q[i][j]  <= cur_a[i][j];
          pe_en_q[i][j] <= cur_en[i][j];
          pe_ld_q[i][j] <= cur_ld[i][j];
          if (cur_ld[i][j]) pe_w_q[i][j] <= w_above[i][j];
          pe_ps_q[i][j] <= ps_above[i][j] + (cur_en[i][j] ? cur_a[i][j] * pe_w_q[i][j] : '0);
        end
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    assign out_sum[j] = pe_ps_q[N-1][j];
  end

  // ---------------- scoreboard ----------------
  logic [2*D-1:0] exp_q [$];
  logic [IW-1:0]  idx_q [$];
  int             hs_q  [$];
  int             rv_hist [$];
  int total = 0;
  int bad   = 0;
  int done_cnt = 0, done_cyc = 0, rv_cnt = 0, last_rv = 0, en_cnt = 0, w_leak = 0;

  logic [D-1:0]   w_tile [N][N];
  logic [2*D-1:0] a_rows [16];
  int             gaps   [16];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [2*D-1:0] golden(input logic [2*D-1:0] a);
    logic [2*D-1:0] res;
    logic [D-1:0]   acc;
    res = '0;
    for (int j = 0; j < N; j++) begin
      acc = '0;
      for (int i = 0; i < N; i++) acc = acc + a[i*D +: D] * w_tile[i][j];
      res[j*D +: D] = acc;
    end
    return res;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin : mon
    logic [2*D-1:0] e;
    int h;
    if (!reset) begin
      if (r_valid) begin
        if (exp_q.size() == 0) begin
          check_val("r_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          h = hs_q.pop_front();
          check_val("r_data", r_data, e);
          check_val("r_index", 64'(r_index), 64'(idx_q.pop_front()));
          check_val("r_latency", 64'(cyc - h), 64'(LAT + N));
        end
        rv_cnt++;
        last_rv = cyc;
        rv_hist.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (enable_mult != '0) en_cnt++;
      if (dbg_state != 3'd2 && (load_weight != '0 || in_weights != '0)) w_leak++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_tile(input logic [D-1:0] w00, w01, w10, w11);
    w_tile[0][0] = w00; w_tile[0][1] = w01;
    w_tile[1][0] = w10; w_tile[1][1] = w11;
  endtask

  task automatic send_w(input int k);
    int t = 0;
    w_valid = 1'b1;
    for (int j = 0; j < N; j++) w_data[j] = w_tile[k][j];
    while (!w_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!w_ready) check_val("w_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    w_valid = 1'b0;
    w_data  = '0;
  endtask

  task automatic send_a(input logic [2*D-1:0] row, input int idx);
    int t = 0;
    a_valid = 1'b1;
    a_data  = row;
    while (!a_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!a_ready) begin
      check_val("a_ready_timeout", 64'd0, 64'd1);
    end else begin
      exp_q.push_back(golden(row));
      idx_q.push_back(IW'(idx));
      hs_q.push_back(cyc);
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    a_data  = '0;
  endtask

  task automatic run_job(input int n_cfg, input int n_send);
    start    = 1'b1;
    num_rows = RW'(n_cfg);
    @(posedge clk); #1;
    start    = 1'b0;
    for (int k = 0; k < N; k++) send_w(k);
    for (int r = 0; r < n_send; r++) begin
      repeat (gaps[r]) begin @(posedge clk); #1; end
      send_a(a_rows[r], r);
    end
  endtask

  task automatic wait_done();
    int c0 = done_cnt;
    int t  = 0;
    while (done_cnt == c0 && t < 300) begin @(posedge clk); #1; t++; end
    repeat (3) begin @(posedge clk); #1; end
    check_val("done_pulses", 64'(done_cnt - c0), 64'd1);
    check_val("busy_after_done", 64'(busy), 64'd0);
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clear_gaps();
    for (int r = 0; r < 16; r++) gaps[r] = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_rvalid"}, 64'(r_valid), 64'd0);
    check_val({tag, "_rdata"}, r_data, 64'd0);
    check_val({tag, "_rindex"}, 64'(r_index), 64'd0);
    check_val({tag, "_ready"}, {62'd0, w_ready, a_ready}, 64'd0);
    check_val({tag, "_lw_en"}, {60'd0, load_weight, enable_mult}, 64'd0);
    check_val({tag, "_in_w"}, in_weights, 64'd0);
    check_val({tag, "_in_d"}, in_data, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int en0, rv0, n;
    reset = 1'b1; start = 1'b0; num_rows = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    clear_gaps();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_idle_outputs("reset");

    // Single row: [5,6] x [[1,2],[3,4]] = [23,34]
    set_tile(1, 2, 3, 4);
    a_rows[0] = {32'd6, 32'd5};
    run_job(1, 1);
    check_val("golden_23_34", golden(a_rows[0]), {32'd34, 32'd23});
    wait_done();
    check_val("done_after_rv", 64'(done_cyc - last_rv), 64'd1);

    // Three back-to-back rows.
    a_rows[0] = {32'd0, 32'd1};
    a_rows[1] = {32'd1, 32'd0};
    a_rows[2] = {32'd2, 32'd2};
    rv_hist.delete();
    run_job(3, 3);
    wait_done();
    check_val("b2b_spacing", 64'(rv_hist[2] - rv_hist[0]), 64'd2);

    // Two idle cycles between rows.
    gaps[1] = 2;
    rv_hist.delete();
    run_job(3, 3);
    wait_done();
    check_val("gap_spacing", 64'(rv_hist[1] - rv_hist[0]), 64'd3);
    clear_gaps();

    // Empty job.
    en0 = en_cnt; rv0 = rv_cnt;
    run_job(0, 0);
    wait_done();
    check_val("empty_enable", 64'(en_cnt - en0), 64'd0);
    check_val("empty_rvalid", 64'(rv_cnt - rv0), 64'd0);

    // Wraparound arithmetic.
    set_tile(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    a_rows[0] = {32'd1, 32'd1};
    check_val("golden_wrap", golden(a_rows[0]), {32'hFFFF_FFFE, 32'hFFFF_FFFE});
    run_job(1, 1);
    wait_done();

    // Randomised jobs.
    for (int t = 0; t < 3; t++) begin
      set_tile($urandom, $urandom, $urandom, $urandom);
      n = $urandom_range(1, 6);
      for (int r = 0; r < n; r++) begin
        a_rows[r] = {$urandom, $urandom};
        gaps[r]   = $urandom_range(0, 2);
      end
      run_job(n, n);
      wait_done();
    end
    clear_gaps();

    // num_rows above MAX_ROWS is clamped.
    for (int r = 0; r < 16; r++) a_rows[r] = {32'(r + 1), 32'($urandom_range(0, 1000))};
    run_job(20, 16);
    check_val("clamp_a_ready", 64'(a_ready), 64'd0);
    wait_done();

    // Reset in the middle of COMPUTE.
    set_tile(7, 8, 9, 10);
    a_rows[0] = {32'd3, 32'd4};
    run_job(3, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    reset = 1'b0;
    exp_q.delete(); idx_q.delete(); hs_q.delete();
    @(posedge clk); #1;
    a_rows[0] = {32'd2, 32'd1};
    a_rows[1] = {32'd5, 32'd3};
    run_job(2, 2);
    wait_done();

    check_val("weights_only_in_shift", 64'(w_leak), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
